alu_frame_initiator: RTL

Host-side initiator for the UART ALU command protocol. It accepts one command (operation, operand A, operand B) on a valid/ready port and serialises it as three UART bytes: op, A, B. It then waits for the single result byte returned by the ALU end, with a cycle timeout. It sits between a command source (test sequencer or soft core) and the codebase's `uart_tx`/`uart_rx` byte engines, which it drives and consumes directly.

---
 rtl/alu_uart_pkg.sv | 33 +++
 rtl/alu_frame_initiator_if.sv | 34 +++
 rtl/rsp_timer.sv | 29 ++
 rtl/alu_frame_initiator.sv | 132 +++++++++++++
 4 files changed

// File: rtl/alu_uart_pkg.sv
// Shared definitions for the UART ALU command protocol: FSM states, default
// widths and the ALU opcode set.
package alu_uart_pkg;

  localparam int DBIT_DEF  = 8;
  localparam int NB_OP_DEF = 6;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SEND_OP  = 4'd1,
    ST_WAIT_OP  = 4'd2,
    ST_SEND_A   = 4'd3,
    ST_WAIT_A   = 4'd4,
    ST_SEND_B   = 4'd5,
    ST_WAIT_B   = 4'd6,
    ST_WAIT_RSP = 4'd7,
    ST_DONE     = 4'd8
  } state_e;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  function automatic logic is_send(input state_e s);
    return (s == ST_SEND_OP) || (s == ST_SEND_A) || (s == ST_SEND_B);
  endfunction

endpackage

// File: rtl/alu_frame_initiator_if.sv
// Command, tx-engine, rx-engine and response signals of the frame initiator.
// master is the initiator's view, slave the view of everything around it.
interface alu_frame_initiator_if #(
  parameter int DBIT  = alu_uart_pkg::DBIT_DEF,
  parameter int NB_OP = alu_uart_pkg::NB_OP_DEF
);
  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic [NB_OP-1:0] i_op;
  logic [DBIT-1:0]  i_a;
  logic [DBIT-1:0]  i_b;
  logic             o_tx_start;
  logic [DBIT-1:0]  o_tx_data;
  logic             i_tx_done_tick;
  logic             i_rx_done_tick;
  logic [DBIT-1:0]  i_rx_data;
  logic             o_rsp_valid;
  logic [DBIT-1:0]  o_result;
  logic             o_timeout;
  logic             o_stray;
  logic             o_busy;

  modport master (
    input  i_cmd_valid, i_op, i_a, i_b, i_tx_done_tick, i_rx_done_tick, i_rx_data,
    output o_cmd_ready, o_tx_start, o_tx_data, o_rsp_valid, o_result, o_timeout,
           o_stray, o_busy
  );

  modport slave (
    output i_cmd_valid, i_op, i_a, i_b, i_tx_done_tick, i_rx_done_tick, i_rx_data,
    input  o_cmd_ready, o_tx_start, o_tx_data, o_rsp_valid, o_result, o_timeout,
           o_stray, o_busy
  );
endinterface

// File: rtl/rsp_timer.sv
// Response-wait cycle counter: synchronous clear, count enable, and an expire
// flag raised while enabled on the count TIMEOUT_CYC-1.
module rsp_timer #(
  parameter  int TIMEOUT_CYC = 200000,
  localparam int TW          = $clog2(TIMEOUT_CYC)
) (
  input  logic clock,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);
  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear)   count_d = '0;
    else if (i_en) count_d = count_q + TW'(1);
  end

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) count_q <= '0;
    else            count_q <= count_d;
  end

  assign o_expire = i_en && !i_clear && (count_q == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/alu_frame_initiator.sv
// Host-side initiator: serialises one ALU command as op/A/B UART bytes, then
// waits for the single result byte or a timeout. All outputs are registered.
module alu_frame_initiator
  import alu_uart_pkg::*;
#(
  parameter int DBIT        = DBIT_DEF,
  parameter int NB_OP       = NB_OP_DEF,
  parameter int TIMEOUT_CYC = 200000
) (
  input logic                    clock,
  input logic                    i_reset_n,
  alu_frame_initiator_if.master  bus
);
  state_e          state_q, state_d;
  logic [DBIT-1:0] a_q, a_d, b_q, b_d;
  logic            tx_start_q, tx_start_d;
  logic [DBIT-1:0] tx_data_q, tx_data_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DBIT-1:0] result_q, result_d;
  logic            timeout_q, timeout_d;
  logic            stray_q, stray_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic            rsp_first_q, rsp_first_d;
  logic            accept;
  logic            expire;

  assign accept = ready_q && bus.i_cmd_valid;

  // The timer spends the first WAIT_RSP cycle being cleared, so a silent
  // response wait ends TIMEOUT_CYC+1 cycles after entry.
  rsp_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rsp_timer (
    .clock    (clock),
    .i_reset_n(i_reset_n),
    .i_clear  (rsp_first_q),
    .i_en     (state_q == ST_WAIT_RSP),
    .o_expire (expire)
  );

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept) state_d = ST_SEND_OP;
      ST_SEND_OP:  state_d = ST_WAIT_OP;
      ST_WAIT_OP:  if (bus.i_tx_done_tick) state_d = ST_SEND_A;
      ST_SEND_A:   state_d = ST_WAIT_A;
      ST_WAIT_A:   if (bus.i_tx_done_tick) state_d = ST_SEND_B;
      ST_SEND_B:   state_d = ST_WAIT_B;
      ST_WAIT_B:   if (bus.i_tx_done_tick) state_d = ST_WAIT_RSP;
      ST_WAIT_RSP: if (bus.i_rx_done_tick || expire) state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // The op byte is loaded straight into tx_data on accept so it is already
  // on the bus with the first start pulse; tx_data_q is the op register.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    tx_data_d   = tx_data_q;
    result_d    = result_q;
    timeout_d   = timeout_q;
    tx_start_d  = is_send(state_d);
    rsp_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
    ready_d     = (state_d == ST_IDLE);
    rsp_first_d = (state_d == ST_WAIT_RSP) && (state_q != ST_WAIT_RSP);
    stray_d     = bus.i_rx_done_tick && (state_q != ST_WAIT_RSP);
    if (accept) begin
      a_d       = bus.i_a;
      b_d       = bus.i_b;
      tx_data_d = DBIT'(bus.i_op);
    end else if (state_d == ST_SEND_A) begin
      tx_data_d = a_q;
    end else if (state_d == ST_SEND_B) begin
      tx_data_d = b_q;
    end
    if (state_q == ST_WAIT_RSP) begin
      if (bus.i_rx_done_tick) begin
        result_d  = bus.i_rx_data;
        timeout_d = 1'b0;
      end else if (expire) begin
        result_d  = '0;
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      a_q         <= '0;
      b_q         <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      result_q    <= '0;
      timeout_q   <= 1'b0;
      stray_q     <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
      rsp_first_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      rsp_valid_q <= rsp_valid_d;
      result_q    <= result_d;
      timeout_q   <= timeout_d;
      stray_q     <= stray_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      rsp_first_q <= rsp_first_d;
    end
  end

  assign bus.o_cmd_ready = ready_q;
  assign bus.o_tx_start  = tx_start_q;
  assign bus.o_tx_data   = tx_data_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_result    = result_q;
  assign bus.o_timeout   = timeout_q;
  assign bus.o_stray     = stray_q;
  assign bus.o_busy      = busy_q;

endmodule
